noc_tree_port_arbiter: RTL and testbench
========================================

Name: noc_tree_port_arbiter

Overview:
- Shares one NoC-tree router output port among NUM_IN input-control channels carrying single-flit packets of WIDTH_packet bits.
- Uses round-robin arbitration with a one-entry registered output stage, so throughput is one packet per cycle.
- Sits between the input-control modules (packet sources such as data_generator-driven channels) and the router output / next tree level.

Parameters:
- WIDTH_packet, 14, packet width in bits, forwarded unmodified.
- NUM_IN, 4, number of requesting input channels; legal range 2..8.
- IDW, $clog2(NUM_IN), width of grant_id (localparam, not overridable).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  NUM_IN  per-channel packet valid.
- in_data  input  NUM_IN*WIDTH_packet  channel i packet at bits [i*WIDTH_packet +: WIDTH_packet].
- in_ready  output  NUM_IN  one-hot or zero; channel i packet accepted this cycle.
- out_valid  output  1  output register holds a packet.
- out_data  output  WIDTH_packet  held packet.
- out_ready  input  1  downstream accepts out_data this cycle.
- grant_id  output  IDW  index of the channel that sourced out_data.
- busy  output  1  out_valid | (|in_valid).

Behaviour:
- Reset (rst=1 at posedge) sets:
  - out_valid=0, out_data=0, grant_id=0, state=EMPTY.
  - last_grant=NUM_IN-1, so channel 0 has top priority first.
- in_ready is combinational, and is 0 in the reset cycle.
- Handshakes:
  - Input transfer on channel i when in_valid[i]&in_ready[i].
  - Output transfer when out_valid&out_ready.
  - Requester rule: once in_valid[i] rises, it stays high and in_data stays stable until transfer. The bench asserts this.
- load_en = !out_valid | out_ready, meaning the register is empty or drains this cycle.
- Arbitration:
  - When load_en, the winner w is the first i with in_valid[i], searching last_grant+1, last_grant+2, ... modulo NUM_IN.
  - in_ready = onehot(w) & {NUM_IN{load_en & any_valid}}.
  - Otherwise in_ready=0.
- On accept at posedge: out_data<=in_data[w], grant_id<=w, last_grant<=w, out_valid<=1.
- On drain with no accept: out_valid<=0. out_data and grant_id hold their last values.
- On simultaneous drain and accept: the new packet replaces the old one, out_valid stays 1. No bubble.
- Latency: packet accepted at edge N appears on out_data after edge N, so it is visible in cycle N+1.
- Stall: while out_valid&!out_ready, out_data and grant_id are stable, in_ready=0, and last_grant is frozen.
- FSM with 2 states:
  - EMPTY → FULL on accept.
  - FULL → FULL on accept with drain, or on stall.
  - FULL → EMPTY on drain with no valid input.
  - out_valid == (state==FULL).
- Fairness: with all channels continuously valid and out_ready=1, grant order is 0,1,...,NUM_IN-1,0,... A channel waits at most NUM_IN-1 grants.
- Single requester: granted every cycle, with no priority penalty.
- Reset mid-operation: the held packet is discarded, and a packet handshaking in that same cycle is not accepted (in_ready=0).
- No X propagation: in_data is sampled only on accept.

Decomposition:
- Package noc_tree_pkg:
  - WIDTH_packet default constant.
  - typedef logic [WIDTH_packet-1:0] packet_t.
  - typedef enum logic {EMPTY, FULL} arb_state_t.
- Sub-module rr_priority_picker (combinational):
  - Inputs: req[NUM_IN], last_grant.
  - Outputs: onehot grant, index, any.
  - Implemented with double-width masked priority encoding.
- The top level holds the FSM, registers, and data mux.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, then low, with no valids.
  - Required: out_valid=0, out_data=0, grant_id=0, in_ready=0, busy=0 throughout.
- Single channel:
  - Stimulus: channel 2 sends 14'h0600 with out_ready=1.
  - Required: in_ready=4'b0100 in cycle N; out_valid=1, out_data=14'h0600, grant_id=2 in cycle N+1; out_valid=0 in cycle N+2.
- Full contention:
  - Stimulus: all 4 channels valid continuously (data=channel index), out_ready=1, 8 cycles.
  - Required: grant_id sequence 0,1,2,3,0,1,2,3 with out_valid high every cycle after the first.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while channels 1 and 3 are valid.
  - Required: out_data and grant_id are stable and in_ready=0. When out_ready rises, the next grant follows round-robin from the held grant_id.
- Priority rotation:
  - Stimulus: last grant=3, then channels 0 and 3 are valid together.
  - Required: channel 0 wins; next cycle channel 3 wins.
- Mid-operation reset:
  - Stimulus: rst asserted while out_valid=1 and channel 1 is valid.
  - Required: next cycle out_valid=0, in_ready=0 during reset. After release, channel 0 has priority if it is valid alongside channel 1.

Source files
------------

// File: rtl/noc_tree_pkg.sv
// Shared types and defaults for the NoC-tree output-port arbiter.
package noc_tree_pkg;

   localparam int DEF_WIDTH_packet = 14;

   typedef logic [DEF_WIDTH_packet-1:0] packet_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first requester strictly after last_grant, wrapping.
// Requests are doubled so the wrap-around search becomes one lowest-bit isolate.
module rr_priority_picker #(
   parameter  int NUM_IN = 4,
   localparam int IDW    = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [IDW-1:0]    last_grant,
   output logic [NUM_IN-1:0] grant,
   output logic [IDW-1:0]    index,
   output logic              any
);

   logic [2*NUM_IN-1:0] reqDouble_s;
   logic [2*NUM_IN-1:0] maskDouble_s;
   logic [2*NUM_IN-1:0] masked_s;
   logic [2*NUM_IN-1:0] first_s;

   // Window covers positions last_grant+1 .. last_grant+NUM_IN of the doubled vector.
   always_comb begin
      reqDouble_s  = {req, req};
      maskDouble_s = '0;
      for (int j = 0; j < 2 * NUM_IN; j++) begin
         maskDouble_s[j] = (j > int'(last_grant)) && (j <= int'(last_grant) + NUM_IN);
      end
      masked_s = reqDouble_s & maskDouble_s;
      first_s  = masked_s & (-masked_s);
      grant    = first_s[NUM_IN-1:0] | first_s[2*NUM_IN-1:NUM_IN];
      index    = '0;
      for (int j = 0; j < 2 * NUM_IN; j++) begin
         index = index | ({IDW{first_s[j]}} & IDW'(j % NUM_IN));
      end
      any = |req;
   end

endmodule

// File: rtl/noc_tree_port_arbiter.sv
// Round-robin arbiter sharing one router output port among NUM_IN channels,
// with a single registered output stage that refills on the draining cycle.
module noc_tree_port_arbiter
   import noc_tree_pkg::*;
#(
   parameter  int WIDTH_packet = DEF_WIDTH_packet,
   parameter  int NUM_IN       = 4,
   localparam int IDW          = $clog2(NUM_IN)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_IN-1:0]              in_valid,
   input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
   output logic [NUM_IN-1:0]              in_ready,
   output logic                           out_valid,
   output logic [WIDTH_packet-1:0]        out_data,
   input  logic                           out_ready,
   output logic [IDW-1:0]                 grant_id,
   output logic                           busy
);

   arb_state_t              state_r;
   logic [IDW-1:0]          lastGrant_r;
   logic [WIDTH_packet-1:0] outData_r;
   logic [IDW-1:0]          grantId_r;

   logic [NUM_IN-1:0]       pickOnehot_s;
   logic [IDW-1:0]          pickIdx_s;
   logic                    pickAny_s;
   logic                    loadEn_s;
   logic                    accept_s;
   logic [WIDTH_packet-1:0] selData_s;

   rr_priority_picker #(
      .NUM_IN(NUM_IN)
   ) u_picker (
      .req       (in_valid),
      .last_grant(lastGrant_r),
      .grant     (pickOnehot_s),
      .index     (pickIdx_s),
      .any       (pickAny_s)
   );

   // Handshake decode; reset suppresses acceptance so nothing is lost into a cleared stage.
   always_comb begin
      loadEn_s  = (state_r == EMPTY) | out_ready;
      accept_s  = loadEn_s & pickAny_s & ~rst;
      in_ready  = pickOnehot_s & {NUM_IN{accept_s}};
      selData_s = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         selData_s = selData_s |
                     (in_data[i*WIDTH_packet +: WIDTH_packet] & {WIDTH_packet{pickOnehot_s[i]}});
      end
   end

   // Output-stage FSM with held packet, source id and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= EMPTY;
         outData_r   <= '0;
         grantId_r   <= '0;
         lastGrant_r <= IDW'(NUM_IN - 1);
      end else begin
         if (accept_s) begin
            outData_r   <= selData_s;
            grantId_r   <= pickIdx_s;
            lastGrant_r <= pickIdx_s;
         end else begin
            outData_r   <= outData_r;
            grantId_r   <= grantId_r;
            lastGrant_r <= lastGrant_r;
         end
         case (state_r)
            EMPTY: state_r <= accept_s ? FULL : EMPTY;
            FULL: begin
               if (accept_s) begin
                  state_r <= FULL;
               end else if (out_ready) begin
                  state_r <= EMPTY;
               end else begin
                  state_r <= FULL;
               end
            end
            default: state_r <= EMPTY;
         endcase
      end
   end

   assign out_valid = (state_r == FULL);
   assign out_data  = outData_r;
   assign grant_id  = grantId_r;
   assign busy      = out_valid | (|in_valid);

endmodule

// File: tb/tb_noc_tree_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_noc_tree_port_arbiter;

   localparam int N = 4;
   localparam int W = 14;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_ready;
   logic [1:0]     grant_id;
   logic           busy;

   int tests = 0;
   int fails = 0;

   // model state
   bit             mInit = 1'b0;
   bit             mValid;
   logic [W-1:0]   mData;
   int             mGrant;
   int             mLast;
   logic [N-1:0]   edgeAck = '0;
   bit             edgeRst = 1'b0;
   logic [N-1:0]   pend = '0;
   logic [W-1:0]   pendData [N];

   noc_tree_port_arbiter #(.WIDTH_packet(W), .NUM_IN(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] chData(input int i);
      return in_data[i*W +: W];
   endfunction

   // First valid channel after 'last', wrapping; -1 when none.
   function automatic int winner(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] expReady();
      int w;
      w = winner(in_valid, mLast);
      if (rst || w < 0 || (mValid && !out_ready)) return '0;
      return N'(1) << w;
   endfunction

   // Model update and requester-rule check at each rising edge.
   always @(posedge clk) begin
      int  w;
      bit  acc;
      w   = winner(in_valid, mLast);
      acc = mInit && !rst && (w >= 0) && (!mValid || out_ready);
      edgeAck = acc ? (N'(1) << w) : '0;
      edgeRst = rst;
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
               tests++;
               if (!in_valid[i] || chData(i) !== pendData[i]) begin
                  fails++;
                  $display("FAIL requester_rule ch%0d: valid %0b data %0h held %0h", i, in_valid[i], chData(i), pendData[i]);
               end
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         pend[i]     = in_valid[i] && !edgeAck[i] && !rst;
         pendData[i] = chData(i);
      end
      if (rst) begin
         mInit = 1'b1; mValid = 1'b0; mData = '0; mGrant = 0; mLast = N - 1;
      end else if (acc) begin
         mValid = 1'b1; mData = chData(w); mGrant = w; mLast = w;
      end else if (out_ready) begin
         mValid = 1'b0;
      end
   end

   // Per-cycle compare of every DUT output against the model.
   always @(negedge clk) begin
      if (mInit) begin
         check("m_out_valid", 32'(out_valid), 32'(mValid));
         check("m_out_data",  32'(out_data),  32'(mData));
         check("m_grant_id",  32'(grant_id),  32'(mGrant));
         check("m_in_ready",  32'(in_ready),  32'(expReady()));
         check("m_busy",      32'(busy),      32'(mValid | (|in_valid)));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic setCh(input int i, input logic [W-1:0] d);
      in_data[i*W +: W] = d;
   endtask

   // Reset with current inputs held for the reset cycle, then drop requests.
   task automatic endPhase();
      rst = 1'b1;
      cyc();
      rst = 1'b0; in_valid = '0; out_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
      // Reset then idle
      cyc();
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      cyc();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("idle_out_valid", 32'(out_valid), 32'd0);
         check("idle_out_data", 32'(out_data), 32'd0);
         check("idle_grant_id", 32'(grant_id), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
         cyc();
      end

      // Single channel
      in_valid = 4'b0100; setCh(2, 14'h0600);
      @(negedge clk);
      check("single_in_ready", 32'(in_ready), 32'h4);
      cyc();
      in_valid = '0;
      @(negedge clk);
      check("single_out_valid", 32'(out_valid), 32'd1);
      check("single_out_data", 32'(out_data), 32'h0600);
      check("single_grant_id", 32'(grant_id), 32'd2);
      cyc();
      @(negedge clk);
      check("single_drained", 32'(out_valid), 32'd0);
      endPhase();

      // Full contention
      in_valid = 4'b1111;
      for (int i = 0; i < N; i++) setCh(i, W'(i));
      @(negedge clk);
      check("cont_first_ready", 32'(in_ready), 32'h1);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         @(negedge clk);
         check("cont_out_valid", 32'(out_valid), 32'd1);
         check("cont_grant_id", 32'(grant_id), 32'((k - 1) % N));
         check("cont_out_data", 32'(out_data), 32'((k - 1) % N));
      end
      cyc();
      endPhase();

      // Backpressure
      in_valid = 4'b1010; setCh(1, 14'h0111); setCh(3, 14'h0333); out_ready = 1'b0;
      @(negedge clk);
      check("bp_first_ready", 32'(in_ready), 32'h2);
      cyc();
      setCh(1, 14'h0112);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_data", 32'(out_data), 32'h0111);
         check("bp_grant_id", 32'(grant_id), 32'd1);
         cyc();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", 32'(in_ready), 32'h8);
      cyc();
      @(negedge clk);
      check("bp_next_grant", 32'(grant_id), 32'd3);
      check("bp_next_data", 32'(out_data), 32'h0333);
      endPhase();

      // Priority rotation
      in_valid = 4'b1000; setCh(3, 14'h0303);
      @(negedge clk);
      check("rot_prime_ready", 32'(in_ready), 32'h8);
      cyc();
      in_valid = 4'b1001; setCh(0, 14'h0010); setCh(3, 14'h0313);
      @(negedge clk);
      check("rot_ch0_ready", 32'(in_ready), 32'h1);
      cyc();
      in_valid = 4'b1000;
      @(negedge clk);
      check("rot_grant0", 32'(grant_id), 32'd0);
      check("rot_ch3_ready", 32'(in_ready), 32'h8);
      cyc();
      in_valid = '0;
      @(negedge clk);
      check("rot_grant3", 32'(grant_id), 32'd3);
      check("rot_data3", 32'(out_data), 32'h0313);
      cyc();

      // Mid-operation reset
      in_valid = 4'b0010; setCh(1, 14'h0121); out_ready = 1'b0;
      cyc();
      setCh(1, 14'h0122); rst = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("mrst_held", 32'(out_valid), 32'd1);
      check("mrst_in_ready", 32'(in_ready), 32'd0);
      cyc();
      rst = 1'b0; in_valid = 4'b0011; setCh(0, 14'h0020);
      @(negedge clk);
      check("mrst_cleared", 32'(out_valid), 32'd0);
      check("mrst_prio_ready", 32'(in_ready), 32'h1);
      cyc();
      @(negedge clk);
      check("mrst_grant0", 32'(grant_id), 32'd0);
      check("mrst_data0", 32'(out_data), 32'h0020);
      endPhase();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!in_valid[i] || edgeAck[i] || edgeRst) begin
               in_valid[i] = ($urandom_range(0, 2) != 0);
               setCh(i, W'($urandom));
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 63) == 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
